// File: rtl/mem_resp_bram.sv
// mem_resp_bram: block-RAM memory responder, single-word writes, BURST-word reads.
// Optional MEM_RESP_STALL_EN adds an LFSR-driven pseudo-random stall.
module mem_resp_bram #(
  parameter int AN     = 24,
  parameter int DN     = 16,
  parameter int IDN    = 2,
  parameter int BURST  = 8,
  parameter int MEM_AW = 12,
  parameter int QD     = 4
) (
  input  logic           clkSYS,
  input  logic           n_reset,
  input  logic [AN-1:0]  addr,
  input  logic [DN-1:0]  data,
  input  logic [IDN-1:0] id,
  input  logic           req,
  input  logic           wr,
  output logic           ack,
  output logic [DN-1:0]  mem_data,
  output logic [IDN-1:0] mem_id,
  output logic           mem_valid
);

  localparam int BW = $clog2(BURST);
  localparam int PW = $clog2(QD);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t state, state_d;

  logic [DN-1:0]     ram [2**MEM_AW];
  logic [MEM_AW-1:0] q_addr [QD];
  logic [IDN-1:0]    q_id [QD];

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty;

  logic [BW-1:0]     beat, beat_d;
  logic [MEM_AW-1:0] base;
  logic [IDN-1:0]    cur_id;

  logic              stall;
  logic              rd_ack, wr_ack;
  logic              pop, issue;
  logic [MEM_AW-1:0] iss_addr;
  logic [IDN-1:0]    iss_id;

  // upper address bits alias onto the RAM
  logic addr_unused;
  assign addr_unused = ^addr[AN-1:MEM_AW];

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr;

  // free-running stall source
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0],
                           lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[2:0] == 3'd0);
`else
  assign stall = 1'b0;
`endif

  assign full  = (count == CW'(QD));
  assign empty = (count == '0);

  assign rd_ack = n_reset & req & ~wr & ~full & ~stall;
  assign wr_ack = n_reset & req & wr & empty
                & (state == S_IDLE) & ~stall;
  assign ack    = rd_ack | wr_ack;

  // read engine next-state and beat issue
  always_comb begin
    state_d  = state;
    beat_d   = beat;
    pop      = 1'b0;
    issue    = 1'b0;
    iss_addr = base + MEM_AW'(beat);
    iss_id   = cur_id;
    unique case (state)
      S_IDLE: begin
        if (!empty && !stall) begin
          pop      = 1'b1;
          issue    = 1'b1;
          iss_addr = q_addr[rd_ptr];
          iss_id   = q_id[rd_ptr];
          beat_d   = BW'(1);
          state_d  = S_BURST;
        end
      end
      S_BURST: begin
        if (!stall) begin
          issue  = 1'b1;
          beat_d = beat + BW'(1);
          if (beat == BW'(BURST - 1))
            state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // engine state, beat counter and burst context
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      beat   <= '0;
      base   <= '0;
      cur_id <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      if (pop) begin
        base   <= q_addr[rd_ptr];
        cur_id <= q_id[rd_ptr];
      end
    end
  end

  // command FIFO pointers and occupancy
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_ack) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      unique case ({rd_ack, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // command FIFO storage
  always_ff @(posedge clkSYS) begin
    if (rd_ack) begin
      q_addr[wr_ptr] <= addr[MEM_AW-1:0];
      q_id[wr_ptr]   <= id;
    end
  end

  // RAM write port
  always_ff @(posedge clkSYS) begin
    if (wr_ack)
      ram[addr[MEM_AW-1:0]] <= data;
  end

  // registered RAM read with id/valid pipelined alongside
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
      mem_id    <= '0;
    end else begin
      mem_valid <= issue;
      if (issue) begin
        mem_data <= ram[iss_addr];
        mem_id   <= iss_id;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_bram.sv
// tb_mem_resp_bram: scoreboard bench for mem_resp_bram.
// Default build (no stall generator), exact cycle timing checked.
module tb_mem_resp_bram;

  localparam int AN     = 24;
  localparam int DN     = 16;
  localparam int IDN    = 2;
  localparam int BURST  = 8;
  localparam int MEM_AW = 12;
  localparam int QD     = 4;

  typedef struct packed {
    logic [DN-1:0]  d;
    logic [IDN-1:0] i;
  } beat_t;

  logic           clkSYS = 1'b0;
  logic           n_reset = 1'b0;
  logic [AN-1:0]  addr = '0;
  logic [DN-1:0]  data = '0;
  logic [IDN-1:0] id = '0;
  logic           req = 1'b0;
  logic           wr = 1'b0;
  logic           ack;
  logic [DN-1:0]  mem_data;
  logic [IDN-1:0] mem_id;
  logic           mem_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  beat_t          sb[$];
  beat_t          mon_e;
  int             vcyc[$];
  logic [DN-1:0]  vdata[$];
  logic [IDN-1:0] vid[$];
  logic [DN-1:0]  model [2**MEM_AW];

  mem_resp_bram #(
    .AN(AN), .DN(DN), .IDN(IDN),
    .BURST(BURST), .MEM_AW(MEM_AW), .QD(QD)
  ) dut (
    .clkSYS(clkSYS),
    .n_reset(n_reset),
    .addr(addr),
    .data(data),
    .id(id),
    .req(req),
    .wr(wr),
    .ack(ack),
    .mem_data(mem_data),
    .mem_id(mem_id),
    .mem_valid(mem_valid)
  );

  always #5 clkSYS = ~clkSYS;

  always @(posedge clkSYS) cyc <= cyc + 1;

  always @(negedge clkSYS) begin
    if (n_reset && mem_valid) begin
      vcyc.push_back(cyc);
      vdata.push_back(mem_data);
      vid.push_back(mem_id);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected cyc=%0d data=%h id=%0d expected no beat",
                 cyc, mem_data, mem_id);
      end else begin
        mon_e = sb.pop_front();
        if (mem_data !== mon_e.d || mem_id !== mon_e.i) begin
          errors++;
          $display("FAIL beat cyc=%0d data=%h id=%0d expected data=%h id=%0d",
                   cyc, mem_data, mem_id, mon_e.d, mon_e.i);
        end
      end
    end
  end

  task automatic vclear();
    vcyc.delete();
    vdata.delete();
    vid.delete();
  endtask

  task automatic send(input logic w, input logic [AN-1:0] a,
                      input logic [DN-1:0] d, input logic [IDN-1:0] i,
                      output int acyc);
    bit got;
    logic [MEM_AW-1:0] x;
    got  = 1'b0;
    acyc = -1;
    req  = 1'b1;
    wr   = w;
    addr = a;
    data = d;
    id   = i;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clkSYS);
      if (ack === 1'b1) begin
        got  = 1'b1;
        acyc = cyc;
        if (w) begin
          model[a[MEM_AW-1:0]] = d;
        end else begin
          for (int b = 0; b < BURST; b++) begin
            x = a[MEM_AW-1:0] + MEM_AW'(b);
            sb.push_back('{d: model[x], i: i});
          end
        end
      end
      @(posedge clkSYS);
      #1;
    end
    req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout addr=%h wr=%0b got no ack expected ack", a, w);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++)
      @(posedge clkSYS);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left=%0d expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clkSYS);
    #1;
  endtask

  task automatic test_reset();
    req = 1'b1;
    wr  = 1'b0;
    #3;
    checks += 4;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b expected 0", mem_valid);
    end
    if (mem_data !== '0) begin
      errors++;
      $display("FAIL rst_data got=%h expected 0", mem_data);
    end
    if (mem_id !== '0) begin
      errors++;
      $display("FAIL rst_id got=%0d expected 0", mem_id);
    end
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack got=%b expected 0", ack);
    end
    req = 1'b0;
    @(posedge clkSYS);
    @(posedge clkSYS);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic fill();
    int t;
    for (int i = 0; i < 2**MEM_AW; i++)
      send(1'b1, AN'(i), DN'(i * 40503 + 17), IDN'(i), t);
  endtask

  task automatic test_write_read();
    int tw, t;
    vclear();
    send(1'b1, 24'h000010, 16'h1234, 2'd3, tw);
    send(1'b0, 24'h000010, 16'h0000, 2'd1, t);
    drain();
    checks += 2;
    if (t != tw + 1) begin
      errors++;
      $display("FAIL wr_rd_ack got=%0d expected %0d", t, tw + 1);
    end
    if (vcyc.size() != BURST) begin
      errors++;
      $display("FAIL wr_rd_beats got=%0d expected %0d", vcyc.size(), BURST);
    end else begin
      checks += 4;
      if (vcyc[0] != t + 2) begin
        errors++;
        $display("FAIL wr_rd_first got=%0d expected %0d", vcyc[0], t + 2);
      end
      if (vcyc[BURST-1] != t + BURST + 1) begin
        errors++;
        $display("FAIL wr_rd_last got=%0d expected %0d",
                 vcyc[BURST-1], t + BURST + 1);
      end
      if (vdata[0] !== 16'h1234) begin
        errors++;
        $display("FAIL wr_rd_data got=%h expected 1234", vdata[0]);
      end
      if (vid[BURST-1] !== 2'd1) begin
        errors++;
        $display("FAIL wr_rd_id got=%0d expected 1", vid[BURST-1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DN-1:0] exp_d [BURST];
    logic [AN-1:0] ra [2];
    int t;
    exp_d[0] = 16'h00A0;
    exp_d[1] = 16'h00A1;
    for (int k = 0; k < 6; k++)
      exp_d[k+2] = DN'(16'h00B0 + k);
    send(1'b1, 24'h000FFE, 16'h00A0, 2'd0, t);
    send(1'b1, 24'h000FFF, 16'h00A1, 2'd0, t);
    for (int k = 0; k < 6; k++)
      send(1'b1, AN'(k), DN'(16'h00B0 + k), 2'd0, t);
    ra[0] = 24'h000FFE;
    ra[1] = 24'h001FFE;
    for (int r = 0; r < 2; r++) begin
      vclear();
      send(1'b0, ra[r], 16'h0000, IDN'(r + 2), t);
      drain();
      checks++;
      if (vdata.size() != BURST) begin
        errors++;
        $display("FAIL wrap_beats addr=%h got=%0d expected %0d",
                 ra[r], vdata.size(), BURST);
      end else begin
        for (int k = 0; k < BURST; k++) begin
          checks++;
          if (vdata[k] !== exp_d[k]) begin
            errors++;
            $display("FAIL wrap_data addr=%h beat=%0d got=%h expected %h",
                     ra[r], k, vdata[k], exp_d[k]);
          end
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int ac [6];
    int exp_c;
    vclear();
    for (int k = 0; k < 6; k++)
      send(1'b0, AN'(24'h000100 + 16 * k), 16'h0000, IDN'(k), ac[k]);
    drain();
    for (int k = 1; k < 6; k++) begin
      exp_c = (k < QD + 1) ? ac[0] + k : ac[0] + 2 + BURST;
      checks++;
      if (ac[k] != exp_c) begin
        errors++;
        $display("FAIL full_ack n=%0d got=%0d expected %0d", k, ac[k], exp_c);
      end
    end
    checks++;
    if (vcyc.size() != 6 * BURST) begin
      errors++;
      $display("FAIL full_beats got=%0d expected %0d", vcyc.size(), 6 * BURST);
    end else begin
      checks += 2;
      if (vcyc[0] != ac[0] + 2) begin
        errors++;
        $display("FAIL full_first got=%0d expected %0d", vcyc[0], ac[0] + 2);
      end
      if (vcyc[6*BURST-1] != ac[0] + 6 * BURST + 1) begin
        errors++;
        $display("FAIL full_contig got=%0d expected %0d",
                 vcyc[6*BURST-1], ac[0] + 6 * BURST + 1);
      end
    end
  endtask

  task automatic test_write_order();
    int t1, t2, tw, t3;
    vclear();
    send(1'b0, 24'h000200, 16'h0000, 2'd1, t1);
    send(1'b0, 24'h000300, 16'h0000, 2'd2, t2);
    send(1'b1, 24'h000300, 16'hBEEF, 2'd0, tw);
    send(1'b0, 24'h000300, 16'h0000, 2'd3, t3);
    drain();
    checks += 2;
    if (tw != t1 + 1 + 2 * BURST) begin
      errors++;
      $display("FAIL order_wr_ack got=%0d expected %0d", tw, t1 + 1 + 2 * BURST);
    end
    if (vdata.size() != 3 * BURST) begin
      errors++;
      $display("FAIL order_beats got=%0d expected %0d", vdata.size(), 3 * BURST);
    end else begin
      checks++;
      if (vdata[2*BURST] !== 16'hBEEF) begin
        errors++;
        $display("FAIL order_data got=%h expected beef", vdata[2*BURST]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, t2;
    vclear();
    send(1'b0, 24'h000400, 16'h0000, 2'd2, t);
    for (int k = 0; k < 20 && cyc < t + 4; k++)
      @(negedge clkSYS);
    #1;
    n_reset = 1'b0;
    req = 1'b1;
    wr = 1'b0;
    #1;
    checks += 5;
    if (vcyc.size() != 3) begin
      errors++;
      $display("FAIL mid_pre_beats got=%0d expected 3", vcyc.size());
    end
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got=%b expected 0", mem_valid);
    end
    if (mem_data !== '0) begin
      errors++;
      $display("FAIL mid_data got=%h expected 0", mem_data);
    end
    if (mem_id !== '0) begin
      errors++;
      $display("FAIL mid_id got=%0d expected 0", mem_id);
    end
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_ack got=%b expected 0", ack);
    end
    req = 1'b0;
    sb.delete();
    @(posedge clkSYS);
    @(posedge clkSYS);
    #1;
    n_reset = 1'b1;
    vclear();
    send(1'b0, 24'h000408, 16'h0000, 2'd1, t2);
    drain();
    checks++;
    if (vcyc.size() != BURST) begin
      errors++;
      $display("FAIL mid_post_beats got=%0d expected %0d", vcyc.size(), BURST);
    end else begin
      checks++;
      if (vcyc[0] != t2 + 2) begin
        errors++;
        $display("FAIL mid_latency got=%0d expected %0d", vcyc[0], t2 + 2);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    fill();
    test_write_read();
    test_wrap();
    test_fifo_full();
    test_write_order();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_resp_bram.md
# mem_resp_bram

On-chip block-RAM responder for the arbiter memory interface, standing in for `sdram` on the memory side of `arbiter_sync_pri`. It accepts single-word write requests and burst read requests. Reads return `BURST` consecutive words tagged with the requester id. It is used for bring-up and simulation of display, ADC and test clients without external DRAM, and lets the arbiter and client state machines be exercised against a deterministic, optionally stalling memory.

## Interface
- `AN`, 24: request address width (word address).
- `DN`, 16: data width.
- `IDN`, 2: requester id width.
- `BURST`, 8: words returned per read request; power of two, ≥2.
- `MEM_AW`, 12: RAM address width; RAM holds 2^MEM_AW words and is indexed by `addr[MEM_AW-1:0]`.
- `QD`, 4: read command FIFO depth; power of two.

Ports:
- `clkSYS`  in  1  system clock; all logic on the rising edge.
- `n_reset`  in  1  asynchronous active-low reset.
- `addr`  in  AN  request word address.
- `data`  in  DN  write data.
- `id`  in  IDN  requester id.
- `req`  in  1  request valid; held until `ack`.
- `wr`  in  1  1 = write, 0 = burst read.
- `ack`  out  1  request accepted this cycle; combinational.
- `mem_data`  out  DN  read data beat; registered.
- `mem_id`  out  IDN  id of the read owning this beat; registered.
- `mem_valid`  out  1  `mem_data`/`mem_id` valid; registered.

## Operation
- Read accept: `ack = req & ~wr & ~full & ~stall`.
  - `{addr[MEM_AW-1:0], id}` is pushed into the FIFO.
  - `full` is decoded from the registered FIFO count. A slot freed by a pop becomes visible the cycle after the pop.
- Write accept: `ack = req & wr & fifo_empty & (state==IDLE) & ~stall`.
  - RAM is written with `data` at `addr[MEM_AW-1:0]` in the ack cycle.
  - Writes are blocked while any read is pending or in flight, which guarantees program order.
- Read engine states:
  - IDLE: when the FIFO is non-empty and there is no stall, pop, load base address and id, issue beat 0, and go to BURST with `beat=1`.
  - BURST: each non-stall cycle, issue a RAM read at `base + beat` (mod 2^MEM_AW, linear with no burst alignment) and increment `beat`.
  - After issuing beat `BURST-1`, return to IDLE. The next pop can occur the following cycle, so back-to-back bursts have no idle beat between them.
- RAM has a registered output. `mem_valid`/`mem_id` are pipelined alongside it, so each issued beat appears 1 cycle after its issue.
- `mem_valid` is deasserted on every cycle with no beat issued in the previous cycle. `mem_data` holds its last value.
- Upper address bits `addr[AN-1:MEM_AW]` are ignored (aliasing).
- Reset mid-operation:
  - FIFO is emptied, engine goes to IDLE, `beat` is cleared, and the in-flight beat is dropped.
  - RAM contents are not cleared.

## Timing
- Reset values: `mem_valid=0`, `mem_data=0`, `mem_id=0`, FIFO count 0, state IDLE.
- `ack` is 0 while `n_reset=0`.
- Read latency from an idle engine: ack in cycle t, then pop/beat 0 issue in t+1, then `mem_valid` in t+2 through t+BURST+1 contiguously (no stalls).
- Write latency: data is readable by a read acked 1 or more cycles after the write ack.
- Throughput: 1 read word/cycle sustained; 1 write/cycle when no reads are pending.
- Simultaneous push and pop in one cycle: count is unchanged; the popped entry is the oldest.

## Configuration
- Macro `MEM_RESP_STALL_EN`: compiles in a pseudo-random stall generator.
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1, advancing every cycle after reset.
  - `stall = (lfsr[2:0]==0)`. A stall forces `ack=0` and prevents both beat issue and pop, which leaves a `mem_valid` gap one cycle later.
- Without the macro: `stall` is tied to 0 and no LFSR is present. The timing above is exact.

## Test plan
- Write then read: write 16'h1234 at 0x000010 with id 3, then read 0x000010 with id 1.
  - Ack at t.
  - `mem_valid` at t+2 through t+9, `mem_id=1`.
  - First beat is 16'h1234; subsequent beats are the contents of 0x11 through 0x17.
- Address wrap: preload 0xFFE to 0xFFF with 16'hA0/16'hA1 and 0x000 to 0x005 with 16'hB0 through 16'hB5.
  - Read at 0xFFE returns A0, A1, B0 through B5.
  - Read at 0x1FFE returns the same data (aliasing).
- FIFO full: 6 back-to-back reads (ids 0,1,2,3,0,1) from cycle 0.
  - Acks in cycles 0 through 4; the sixth read is acked in cycle 10.
  - 48 contiguous valid beats start in cycle 2, ids in request order.
- Write ordering: a write requested while 2 reads are queued is not acked until the engine is IDLE and the FIFO is empty. A read issued after it returns the new data.
- Reset mid-burst: deassert `n_reset` at beat 3 of a burst.
  - `mem_valid` drops asynchronously.
  - After release, FIFO is empty and a new read returns correct data with latency 2.
- With `MEM_RESP_STALL_EN`:
  - Over 1000 random reads and writes against a scoreboard, all data and ids match.
  - Every `mem_valid` gap aligns with a cycle where `lfsr[2:0]==0`.
